// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Iterative multiply (radix-2 Booth) / divide (restoring) unit
//             feeding the HI/LO pair. Defining MULDIV_DIV0_EN adds a
//             div_zero flag output.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
`ifdef MULDIV_DIV0_EN
   output logic             div_zero,
`endif
   output logic [WIDTH-1:0] high,
   output logic [WIDTH-1:0] low
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

   localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WIDTH - 1);
   localparam logic [1:0]         c_OP_MULTU = 2'b01;
   localparam logic [1:0]         c_OP_DIV   = 2'b10;

   state_t               state_q;
   logic [c_CNT_W-1:0]   cnt_q;
   logic                 busy_q, done_q;
   logic [WIDTH-1:0]     high_q, low_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [1:0]           op_q;
   logic [WIDTH:0]       mcand_q;
   logic [WIDTH:0]       acc_q, acc_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 qm1_q, qm1_d;

   logic [WIDTH-1:0]     w_abs_a_in, w_abs_b_in, w_lo_in;
   logic [WIDTH:0]       w_mcand_in;
   logic [WIDTH+1:0]     w_sum;
   logic [WIDTH:0]       w_shift, w_trial;
   logic [2*WIDTH-1:0]   w_prod, w_corr, w_prod_fix;
   logic                 w_quo_neg, w_rem_neg, w_b_zero;
   logic [WIDTH-1:0]     w_high_fin, w_low_fin;

   // Operand preparation at acceptance: MULT sign-extends, MULTU zero-extends,
   // division works on magnitudes with the divisor parked in mcand_q.
   assign w_abs_a_in = ((op == c_OP_DIV) && a[WIDTH-1]) ? -a : a;
   assign w_abs_b_in = ((op == c_OP_DIV) && b[WIDTH-1]) ? -b : b;
   assign w_mcand_in = op[1] ? {1'b0, w_abs_b_in} : {(~op[0]) & a[WIDTH-1], a};
   assign w_lo_in    = op[1] ? w_abs_a_in : b;

   assign w_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign w_trial = w_shift - mcand_q;

   always_comb begin
      w_sum = {acc_q[WIDTH], acc_q};
      acc_d = acc_q;
      lo_d  = lo_q;
      qm1_d = qm1_q;
      if (!op_q[1]) begin
         case ({lo_q[0], qm1_q})
            2'b01:   w_sum = {acc_q[WIDTH], acc_q} + {mcand_q[WIDTH], mcand_q};
            2'b10:   w_sum = {acc_q[WIDTH], acc_q} - {mcand_q[WIDTH], mcand_q};
            default: w_sum = {acc_q[WIDTH], acc_q};
         endcase
         acc_d = w_sum[WIDTH+1:1];
         lo_d  = {w_sum[0], lo_q[WIDTH-1:1]};
         qm1_d = lo_q[0];
      end else begin
         acc_d = (w_shift >= mcand_q) ? w_trial : w_shift;
         lo_d  = {lo_q[WIDTH-2:0], (w_shift >= mcand_q)};
      end
   end

   // Booth on the W-bit multiplier treats b as signed; MULTU adds a<<W back.
   assign w_prod     = {acc_q[WIDTH-1:0], lo_q};
   assign w_corr     = ((op_q == c_OP_MULTU) && b_q[WIDTH-1]) ? {a_q, {WIDTH{1'b0}}} : '0;
   assign w_prod_fix = w_prod + w_corr;
   assign w_quo_neg  = (op_q == c_OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
   assign w_rem_neg  = (op_q == c_OP_DIV) && a_q[WIDTH-1];
   assign w_b_zero   = (b_q == '0);

   always_comb begin
      w_high_fin = w_prod_fix[2*WIDTH-1:WIDTH];
      w_low_fin  = w_prod_fix[WIDTH-1:0];
      if (op_q[1]) begin
         if (w_b_zero) begin
            w_high_fin = a_q;
            w_low_fin  = '1;
         end else begin
            w_high_fin = w_rem_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            w_low_fin  = w_quo_neg ? -lo_q : lo_q;
         end
      end
   end

`ifdef MULDIV_DIV0_EN
   logic div_zero_q;
   assign div_zero = div_zero_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         high_q  <= '0;
         low_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         qm1_q   <= 1'b0;
`ifdef MULDIV_DIV0_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  mcand_q <= w_mcand_in;
                  acc_q   <= '0;
                  lo_q    <= w_lo_in;
                  qm1_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
`ifdef MULDIV_DIV0_EN
                  div_zero_q <= 1'b0;
`endif
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + c_CNT_W'(1);
               if (cnt_q == c_LAST) state_q <= S_FIN;
            end
            S_FIN: begin
               high_q  <= w_high_fin;
               low_q   <= w_low_fin;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
`ifdef MULDIV_DIV0_EN
               div_zero_q <= op_q[1] && w_b_zero;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign high = high_q;
   assign low  = low_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Directed-vector bench for muldiv_seq at WIDTH=32 and WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

   localparam logic [1:0] c_MULT = 2'b00, c_MULTU = 2'b01, c_DIV = 2'b10, c_DIVU = 2'b11;

   logic        clk, rst;
   logic        start32, busy32, done32;
   logic [1:0]  op32;
   logic [31:0] a32, b32, hi32, lo32;
   logic        start8, busy8, done8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, hi8, lo8;
`ifdef MULDIV_DIV0_EN
   logic        dz32, dz8;
`endif

   int checks   = 0;
   int failures = 0;
   int lat, bc, ndone, first;
   logic dz_acc;

   muldiv_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(rst), .start(start32), .op(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32),
`ifdef MULDIV_DIV0_EN
      .div_zero(dz32),
`endif
      .high(hi32), .low(lo32));

   muldiv_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8),
`ifdef MULDIV_DIV0_EN
      .div_zero(dz8),
`endif
      .high(hi8), .low(lo8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Accept one op, then count edges until done (bounded) and busy samples.
   task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int l, output int bcount, output logic dz);
      @(negedge clk);
      start32 = 1'b1; op32 = o; a32 = x; b32 = y;
      @(posedge clk); #1;
      start32 = 1'b0;
`ifdef MULDIV_DIV0_EN
      dz = dz32;
`else
      dz = 1'b0;
`endif
      l = 0;
      bcount = busy32 ? 1 : 0;
      while (!done32 && l < 100) begin
         @(posedge clk); #1;
         l++;
         if (busy32) bcount++;
      end
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int l);
      @(negedge clk);
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 1'b0;
      l = 0;
      while (!done8 && l < 100) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   initial begin
      rst = 1'b1;
      start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_high",  hi32, 0);
      chk("rst_low",   lo32, 0);
      chk("rst_busy",  busy32, 0);
      chk("rst_done",  done32, 0);
      chk("rst_busy8", busy8, 0);
      rst = 1'b0;

      run32(c_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc, dz_acc);
      chk("mult_lat",  lat, 33);
      chk("mult_high", hi32, 32'hFFFF_FFFF);
      chk("mult_low",  lo32, 32'hFFFF_FFEB);

      // issued while done is still high
      run32(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz_acc);
      chk("multu_lat",  lat, 33);
      chk("multu_busy", bc, 33);
      chk("multu_high", hi32, 32'hFFFF_FFFE);
      chk("multu_low",  lo32, 32'h0000_0001);
      @(posedge clk); #1;
      chk("done_pulse", done32, 0);
      chk("hold_low",   lo32, 32'h0000_0001);

      run32(c_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, dz_acc);
      chk("div_lat",  lat, 33);
      chk("div_low",  lo32, 32'hFFFF_FFFD);
      chk("div_high", hi32, 32'hFFFF_FFFF);

      run32(c_DIVU, 32'd100, 32'd0, lat, bc, dz_acc);
      chk("divu0_lat",  lat, 33);
      chk("divu0_low",  lo32, 32'hFFFF_FFFF);
      chk("divu0_high", hi32, 32'd100);
`ifdef MULDIV_DIV0_EN
      chk("divu0_flag", dz32, 1);
`endif

      run32(c_MULTU, 32'd3, 32'd5, lat, bc, dz_acc);
      chk("multu35_low",  lo32, 32'd15);
      chk("multu35_high", hi32, 32'd0);
`ifdef MULDIV_DIV0_EN
      chk("dz_clr_start", dz_acc, 0);
      chk("dz_clr_done",  dz32, 0);
`endif

      run8(c_DIV, 8'h80, 8'hFF, lat);
      chk("w8_ovf_lat",  lat, 9);
      chk("w8_ovf_low",  lo8, 8'h80);
      chk("w8_ovf_high", hi8, 8'h00);

      run8(c_MULTU, 8'hFF, 8'hFF, lat);
      chk("w8_multu_high", hi8, 8'hFE);
      chk("w8_multu_low",  lo8, 8'h01);

      run8(c_DIV, 8'h90, 8'h00, lat);
      chk("w8_div0_low",  lo8, 8'hFF);
      chk("w8_div0_high", hi8, 8'h90);
`ifdef MULDIV_DIV0_EN
      chk("w8_div0_flag", dz8, 1);
`endif

      // start and operands disturbed while running
      @(negedge clk);
      start32 = 1'b1; op32 = c_MULT; a32 = 32'd5; b32 = 32'd6;
      @(posedge clk); #1;
      start32 = 1'b0;
      ndone = 0; first = 0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         if (done32) begin
            ndone++;
            if (first == 0) first = k;
         end
         if (k == 5) begin start32 = 1'b1; op32 = c_DIVU; a32 = 32'd9; b32 = 32'd11; end
         if (k == 6) start32 = 1'b0;
      end
      chk("robust_ndone", ndone, 1);
      chk("robust_lat",   first, 33);
      chk("robust_high",  hi32, 32'd0);
      chk("robust_low",   lo32, 32'd30);

      // reset lands on the 10th iteration edge
      @(negedge clk);
      start32 = 1'b1; op32 = c_MULT; a32 = 32'd5; b32 = 32'd6;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy32, 1);
      chk("pre_rst_low",  lo32, 32'd30);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy32, 0);
      chk("abort_high", hi32, 0);
      chk("abort_low",  lo32, 0);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done32) ndone++;
      end
      chk("abort_nodone", ndone, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
